// File: rtl/score_board.sv
// Ninety-Nine score board: ranks the four lowest final scores and counts games and hits.
// Optional hit counter enabled by defining SCORE_BOARD_HITS_EN; otherwise hits reads 8'h00.
module score_board (
  input  logic       rst,
  input  logic       keyclk,
  input  logic [2:0] state,
  input  logic [7:0] score,
  output logic [7:0] best0,
  output logic [7:0] best1,
  output logic [7:0] best2,
  output logic [7:0] best3,
  output logic [3:0] best_valid,
  output logic [7:0] games,
  output logic [2:0] last_rank,
  output logic       new_best,
  output logic [7:0] hits,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [3:0][7:0] best_q, best_d;
  logic [3:0]      valid_q, valid_d;
  logic [7:0]      games_q, games_d;
  logic [2:0]      rank_q, rank_d;
  logic            new_best_q, new_best_d;
  logic [2:0]      pos;
  logic            playing, game_over, commit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)     return v;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign playing   = (state != 3'b000) && (state != 3'b111);
  assign game_over = (state == 3'b111);
  assign commit    = (phase_q == PLAY) && game_over;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE: begin
        if (playing)        phase_d = PLAY;
        else if (game_over) phase_d = DONE;
      end
      PLAY: begin
        if (game_over)              phase_d = DONE;
        else if (state == 3'b000)   phase_d = IDLE;
      end
      DONE: begin
        if (state == 3'b000) phase_d = IDLE;
      end
      default: phase_d = IDLE;
    endcase
  end

  // Scan from the bottom so the lowest qualifying slot wins; ties fall behind.
  always_comb begin
    pos = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i] || (score < best_q[i])) pos = i[2:0];
    end
  end

  always_comb begin
    best_d     = best_q;
    valid_d    = valid_q;
    games_d    = games_q;
    rank_d     = rank_q;
    new_best_d = new_best_q;
    if (commit) begin
      games_d    = bcd_inc(games_q);
      rank_d     = pos;
      new_best_d = (pos == 3'd0);
      if (pos < 3'd4) begin
        for (int i = 1; i < 4; i++) begin
          if (i > int'(pos)) begin
            best_d[i]  = best_q[i-1];
            valid_d[i] = valid_q[i-1];
          end
        end
        best_d[pos[1:0]]  = score;
        valid_d[pos[1:0]] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the async clear resets every
  // table register because the clear button must empty the table in one step.
  always_ff @(posedge keyclk or posedge rst) begin
    if (rst) begin
      phase_q    <= IDLE;
      best_q     <= {4{8'h99}};
      valid_q    <= 4'b0000;
      games_q    <= 8'h00;
      rank_q     <= 3'b111;
      new_best_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      best_q     <= best_d;
      valid_q    <= valid_d;
      games_q    <= games_d;
      rank_q     <= rank_d;
      new_best_q <= new_best_d;
    end
  end

`ifdef SCORE_BOARD_HITS_EN
  logic [7:0] hits_q, hits_d;

  // Hits clear when a game starts and count every further in-play press.
  always_comb begin
    hits_d = hits_q;
    if ((phase_q == IDLE) && playing)      hits_d = 8'h00;
    else if ((phase_q == PLAY) && playing) hits_d = bcd_inc(hits_q);
  end

  always_ff @(posedge keyclk or posedge rst) begin
    if (rst) hits_q <= 8'h00;
    else     hits_q <= hits_d;
  end

  assign hits = hits_q;
`else
  assign hits = 8'h00;
`endif

  assign best0      = best_q[0];
  assign best1      = best_q[1];
  assign best2      = best_q[2];
  assign best3      = best_q[3];
  assign best_valid = valid_q;
  assign games      = games_q;
  assign last_rank  = rank_q;
  assign new_best   = new_best_q;
  assign phase      = phase_q;

endmodule
